// File: rtl/count_game_input.sv
// rtl/count_game_input.sv - key synchroniser/debouncer and num/cst/dzst control FSM for the count game
module count_game_input #(
  parameter int DB_CYCLES = 16,
  parameter int NUM_INIT  = 5,
  parameter int RUN_MAX   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_start,
  input  logic       key_stop,
  output logic [2:0] num,
  output logic       cst,
  output logic       dzst,
  output logic       done,
  output logic [1:0] state
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  // With RUN_MAX=0 the run counter is a single bit held at zero.
  localparam int RW = (RUN_MAX > 0) ? $clog2(RUN_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    RUN  = 2'd2
  } state_t;

  logic [3:0]         raw;
  logic [3:0]         sync1;
  logic [3:0]         sync2;
  logic [3:0]         level;
  logic [3:0]         level_d;
  logic [3:0][CW-1:0] db_cnt;
  logic [3:0]         press;

  state_t             state_q;
  state_t             state_n;
  logic [2:0]         num_n;
  logic               timeout;
  logic [RW-1:0]      run_cnt;

  // Bit order: 0 inc, 1 dec, 2 start, 3 stop.
  assign raw = {key_stop, key_start, key_dec, key_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      db_cnt  <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = level & ~level_d;

  always_comb begin
    state_n = state_q;
    num_n   = num;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (press[0] || press[1] || press[2]) state_n = SEL;
      end
      SEL: begin
        if (press[3])                       state_n = IDLE;
        else if (press[2])                  state_n = RUN;
        else if (press[0] && !press[1])     num_n   = num + 3'd1;
        else if (press[1] && !press[0])     num_n   = num - 3'd1;
      end
      RUN: begin
        if (press[3]) begin
          state_n = SEL;
        end else if (RUN_MAX > 0 && run_cnt == RW'(RUN_MAX - 1)) begin
          state_n = SEL;
          timeout = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      num     <= 3'(NUM_INIT);
      cst     <= 1'b0;
      dzst    <= 1'b0;
      done    <= 1'b0;
      run_cnt <= '0;
    end else begin
      state_q <= state_n;
      num     <= num_n;
      cst     <= (state_n == RUN);
      dzst    <= (state_n != IDLE);
      done    <= timeout;
      if (RUN_MAX == 0 || state_q != RUN) run_cnt <= '0;
      else                                run_cnt <= run_cnt + RW'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_count_game_input.sv
// tb/tb_count_game_input.sv - self-checking bench for count_game_input
module tb_count_game_input;

  typedef struct {
    logic [3:0] keys;
    logic [2:0] num;
    logic [1:0] state;
    logic       cst;
    logic       dzst;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       key_inc, key_dec, key_start, key_stop;
  logic [2:0] num, num_to;
  logic       cst, dzst, done, cst_to, dzst_to, done_to;
  logic [1:0] state, state_to;

  int errors = 0;
  int checks = 0;

  vec_t tbl [14];
  vec_t sb [$];
  vec_t prev;

  count_game_input #(.DB_CYCLES(4), .NUM_INIT(5), .RUN_MAX(0)) u_dut (
    .clk(clk), .rst(rst), .key_inc(key_inc), .key_dec(key_dec),
    .key_start(key_start), .key_stop(key_stop),
    .num(num), .cst(cst), .dzst(dzst), .done(done), .state(state)
  );

  count_game_input #(.DB_CYCLES(4), .NUM_INIT(5), .RUN_MAX(100)) u_to (
    .clk(clk), .rst(rst), .key_inc(key_inc), .key_dec(key_dec),
    .key_start(key_start), .key_stop(key_stop),
    .num(num_to), .cst(cst_to), .dzst(dzst_to), .done(done_to), .state(state_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_keys(input logic [3:0] m);
    {key_stop, key_start, key_dec, key_inc} = m;
  endtask

  // Hold keys 20 clk then release; outputs must change exactly 7 clk after the raw edge.
  task automatic press(input vec_t v, input int idx);
    vec_t e;
    set_keys(v.keys);
    sb.push_back(v);
    repeat (6) @(posedge clk);
    #1;
    chk($sformatf("v%0d early_state", idx), state, prev.state);
    chk($sformatf("v%0d early_num", idx), num, prev.num);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d num", idx), num, e.num);
    chk($sformatf("v%0d state", idx), state, e.state);
    chk($sformatf("v%0d cst", idx), cst, e.cst);
    chk($sformatf("v%0d dzst", idx), dzst, e.dzst);
    prev = e;
    repeat (13) @(posedge clk);
    #1;
    set_keys(4'b0000);
    repeat (12) @(posedge clk);
    #1;
    chk($sformatf("v%0d release_state", idx), state, e.state);
  endtask

  initial begin
    int cst_cnt;
    int done_cnt;
    int done_bad;
    logic cst_prev;

    // keys: {stop,start,dec,inc}
    tbl[0]  = '{4'b0001, 3'd5, 2'd1, 1'b0, 1'b1};
    tbl[1]  = '{4'b0001, 3'd6, 2'd1, 1'b0, 1'b1};
    tbl[2]  = '{4'b0001, 3'd7, 2'd1, 1'b0, 1'b1};
    tbl[3]  = '{4'b0001, 3'd0, 2'd1, 1'b0, 1'b1};
    tbl[4]  = '{4'b0010, 3'd7, 2'd1, 1'b0, 1'b1};
    tbl[5]  = '{4'b0011, 3'd7, 2'd1, 1'b0, 1'b1};
    tbl[6]  = '{4'b0100, 3'd7, 2'd2, 1'b1, 1'b1};
    tbl[7]  = '{4'b0001, 3'd7, 2'd2, 1'b1, 1'b1};
    tbl[8]  = '{4'b0010, 3'd7, 2'd2, 1'b1, 1'b1};
    tbl[9]  = '{4'b1000, 3'd7, 2'd1, 1'b0, 1'b1};
    tbl[10] = '{4'b1000, 3'd7, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{4'b1000, 3'd7, 2'd0, 1'b0, 1'b0};
    tbl[12] = '{4'b0010, 3'd7, 2'd1, 1'b0, 1'b1};
    tbl[13] = '{4'b1100, 3'd7, 2'd0, 1'b0, 1'b0};

    rst = 1'b0;
    set_keys(4'b0000);

    // Reset values, then hold after release
    repeat (10) @(posedge clk);
    #1;
    chk("rst num", num, 5);
    chk("rst cst", cst, 0);
    chk("rst dzst", dzst, 0);
    chk("rst state", state, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst num", num, 5);
    chk("post_rst cst", cst, 0);
    chk("post_rst dzst", dzst, 0);
    chk("post_rst state", state, 0);

    // 3-clk glitch must be filtered
    key_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    key_inc = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("glitch state", state, 0);
    chk("glitch dzst", dzst, 0);
    chk("glitch num", num, 5);

    prev = '{4'b0000, 3'd5, 2'd0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) press(tbl[i], i);
    chk("scoreboard empty", sb.size(), 0);

    // RUN_MAX=100 timeout on u_to
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    key_inc = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    key_inc = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("to sel state", state_to, 1);
    key_start = 1'b1;
    cst_cnt  = 0;
    done_cnt = 0;
    done_bad = 0;
    cst_prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (i == 19) key_start = 1'b0;
      if (cst_to) cst_cnt++;
      if (done_to) begin
        done_cnt++;
        if (cst_to || !cst_prev) done_bad++;
      end
      cst_prev = cst_to;
    end
    chk("to cst cycles", cst_cnt, 100);
    chk("to done pulses", done_cnt, 1);
    chk("to done aligned with cst fall", done_bad, 0);
    chk("to state after", state_to, 1);
    chk("to cst after", cst_to, 0);
    chk("to num", num_to, 5);

    // Async reset mid-RUN on the unlimited instance
    chk("pre_rst run cst", cst, 1);
    chk("pre_rst run state", state, 2);
    #3;
    rst = 1'b0;
    #1;
    chk("async cst", cst, 0);
    chk("async dzst", dzst, 0);
    chk("async num", num, 5);
    chk("async state", state, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
